// File: rtl/counter_12.sv
// Free-running modulo-MODULUS up-counter with asynchronous active-low clear.
// Out-of-range values collapse to zero on the next edge.
module counter_12 #(
   parameter int MODULUS = 12,
   parameter int WIDTH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] count_q;

   // ">=" rather than "==" so an upset to 12..15 self-recovers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else if (count_q >= LAST) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_counter_12.sv
// Bench for counter_12: vector table, directed corner cases,
// and randomized reset traffic against an edge-count model.
module tb_counter_12;

   logic       clk;
   logic       rst;
   logic [3:0] count;

   int n_cmp;
   int n_bad;

   counter_12 dut (
      .clk   (clk),
      .rst   (rst),
      .count (count)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[30];

   task automatic check(input string name, input logic [3:0] act,
                        input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp,
                  $time);
      end
   endtask

   // sample 20 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #20;
   endtask

   task automatic run_to(input logic [3:0] v);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 13; i++) begin
         if (count == v) begin
            hit = 1'b1;
            break;
         end
         tick();
      end
      n_cmp++;
      if (!hit) begin
         n_bad++;
         $display("FAIL run_to: got %b, expected %b within 13 edges",
                  count, v);
      end
   endtask

   int n;
   logic [3:0] exp;

   initial begin
      n_cmp = 0;
      n_bad = 0;

      // 24 counting edges = two full periods, then a synchronous-time
      // reset pulse and a restart
      for (int i = 0; i < 24; i++) begin
         vecs[i].rst = 1'b1;
         vecs[i].exp = 4'((i + 1) % 12);
      end
      vecs[24] = '{rst: 1'b0, exp: 4'd0};
      vecs[25] = '{rst: 1'b0, exp: 4'd0};
      vecs[26] = '{rst: 1'b1, exp: 4'd1};
      vecs[27] = '{rst: 1'b1, exp: 4'd2};
      vecs[28] = '{rst: 1'b1, exp: 4'd3};
      vecs[29] = '{rst: 1'b1, exp: 4'd4};

      rst = 1'b1;
      #5 rst = 1'b0;
      #1 check("reset_async", count, 4'd0);

      // reset hold with clock running
      for (int i = 0; i < 2; i++) begin
         tick();
         check("reset_hold", count, 4'd0);
      end

      // vector table
      for (int i = 0; i < 30; i++) begin
         rst = vecs[i].rst;
         tick();
         check($sformatf("vec%0d", i), count, vecs[i].exp);
      end

      // wrap boundary
      run_to(4'd11);
      tick();
      check("wrap_to_0", count, 4'd0);
      tick();
      check("wrap_to_1", count, 4'd1);

      // asynchronous reset midway between edges
      run_to(4'd7);
      @(negedge clk);
      rst = 1'b0;
      #1 check("mid_async", count, 4'd0);
      tick();
      check("mid_hold", count, 4'd0);
      rst = 1'b1;
      tick();
      check("mid_release", count, 4'd1);

      // reset just before the wrapping edge
      run_to(4'd11);
      @(negedge clk);
      #45 rst = 1'b0;
      #1 check("wrap_rst_async", count, 4'd0);
      tick();
      check("wrap_rst_hold", count, 4'd0);
      rst = 1'b1;
      tick();
      check("wrap_rst_rel1", count, 4'd1);
      tick();
      check("wrap_rst_rel2", count, 4'd2);

      // illegal state recovery
      @(negedge clk);
      force dut.count_q = 4'd14;
      #1 release dut.count_q;
      tick();
      check("illegal_recover", count, 4'd0);
      tick();
      check("illegal_next", count, 4'd1);

      // randomized reset traffic; model counts edges since last clear
      n = 1;
      for (int i = 0; i < 300; i++) begin
         rst = ($urandom_range(0, 7) != 0);
         if (!rst) begin
            n = 0;
            #1 check("rand_async", count, 4'd0);
         end
         tick();
         if (rst) n = n + 1;
         exp = 4'(n % 12);
         check($sformatf("rand%0d", i), count, exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

endmodule
